// File: rtl/fb_fetch_pkg.sv
// rtl/fb_fetch_pkg.sv - fetch-stage types and helpers; carries the shared fb_defines macros so the
// package alone is enough when fb_defines.v is not on the compile list.
`ifndef FB_DEFINES_V
`define FB_DEFINES_V
`define FB_32BITS [31:0]
`define FB_FETCH_BOOT 1'b0
`define FB_FETCH_RUN 1'b1
`define FB_INST_STEP 32'd4
`endif

package fb_fetch_pkg;

  typedef enum logic {
    ST_BOOT = `FB_FETCH_BOOT,
    ST_RUN  = `FB_FETCH_RUN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] INST_STEP = `FB_INST_STEP;

  // Sequential fetch address; wraps naturally at 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + INST_STEP;
  endfunction

endpackage

// File: rtl/fb_defines.v
// rtl/fb_defines.v - shared width, FSM state-code and instruction-step macros for the fetch block
`ifndef FB_DEFINES_V
`define FB_DEFINES_V
`define FB_32BITS [31:0]
`define FB_FETCH_BOOT 1'b0
`define FB_FETCH_RUN 1'b1
`define FB_INST_STEP 32'd4
`endif

// File: rtl/fb_fetch_buf.sv
// rtl/fb_fetch_buf.sv - two-entry in-order instruction buffer (push, pop, flush, count, head).
module fb_fetch_buf
  import fb_fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t ent0_q, ent0_d;
  fetch_entry_t ent1_q, ent1_d;
  logic [1:0]   count_q, count_d;
  logic [1:0]   occ_after_pop;
  logic         do_pop, do_push;

  always_comb begin
    do_pop        = pop_i && (count_q != 2'd0);
    do_push       = push_i && ((count_q != 2'd2) || do_pop);
    occ_after_pop = count_q - {1'b0, do_pop};
    ent0_d        = ent0_q;
    ent1_d        = ent1_q;
    count_d       = count_q;
    if (flush_i) begin
      ent0_d  = '0;
      ent1_d  = '0;
      count_d = 2'd0;
    end else begin
      if (do_pop) begin
        ent0_d = ent1_q;
      end
      // New entry lands in the first slot left free after any same-cycle pop.
      if (do_push) begin
        if (occ_after_pop == 2'd0) begin
          ent0_d = push_entry_i;
        end else begin
          ent1_d = push_entry_i;
        end
      end
      count_d = occ_after_pop + {1'b0, do_push};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = ent0_q;

endmodule

// File: rtl/fb_fetch.sv
// rtl/fb_fetch.sv - instruction fetch stage: BOOT/RUN FSM, pc, single in-flight read, 2-entry buffer.
// Optional FB_FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module fb_fetch
  import fb_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic `FB_32BITS  redirect_pc,
  output logic             imem_en,
  output logic `FB_32BITS  imem_addr,
  input  logic `FB_32BITS  imem_rdata,
  output logic             id_valid,
  input  logic             id_ready,
  output logic `FB_32BITS  id_inst,
  output logic `FB_32BITS  id_pc
`ifdef FB_FETCH_PERF_EN
  ,
  output logic `FB_32BITS  perf_fetch_cnt,
  output logic `FB_32BITS  perf_stall_cnt
`endif
);

  localparam logic [2:0] DEPTH3 = 3'(BUF_DEPTH);

  fetch_state_e state_q, state_d;
  logic         run;

  logic [31:0]  pc_q, pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;

  logic         pop, redir, issue, push;
  logic [2:0]   occ_after;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    run = 1'b0;
    case (state_q)
      ST_RUN:  run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  // Occupancy after this cycle's pop, counting the read still in flight.
  assign pop       = id_valid & id_ready;
  assign redir     = run & redirect_valid;
  assign occ_after = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = run & ~rst & ~redirect_valid & (occ_after < DEPTH3);
  assign push      = inflight_q & ~redir;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redir) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d          = next_pc(pc_q);
      inflight_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push_entry = '{inst: imem_rdata, pc: inflight_pc_q};

  fb_fetch_buf u_buf (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (redir),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .count_o      (count),
    .head_o       (head)
  );

  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign id_valid  = (count != 2'd0) & ~redirect_valid;
  assign id_inst   = head.inst;
  assign id_pc     = head.pc;

`ifdef FB_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= 32'h0000_0000;
      perf_stall_q <= 32'h0000_0000;
    end else begin
      if (pop) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (id_valid & ~id_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fb_fetch.sv
// tb/tb_fb_fetch.sv - directed self-checking bench for fb_fetch; memory returns addr ^ 32'hA5A5_0000.
module tb_fb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
`ifdef FB_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
`ifdef FB_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // One-cycle read latency; a non-read cycle returns a marker that must never reach decode.
  always @(posedge clk) begin
    imem_rdata <= imem_en ? (imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #2;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    #3;
    chk1("rst_imem_en", imem_en, 1'b0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk1("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
`ifdef FB_FETCH_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif

    // Bring-up stream: cycle 0 is BOOT.
    rst = 1'b0;
    #1;
    chk1("boot_imem_en", imem_en, 1'b0);
    step(1'b1, 1'b0, 32'h0);
    chk1("c1_imem_en", imem_en, 1'b1);
    chk("c1_imem_addr", imem_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("c2_imem_addr", imem_addr, 32'h4);
    chk1("c2_id_valid", id_valid, 1'b0);
    step(1'b1, 1'b0, 32'h0);
    chk("c3_imem_addr", imem_addr, 32'h8);
    chk1("c3_id_valid", id_valid, 1'b1);
    chk("c3_id_pc", id_pc, 32'h0);
    chk("c3_id_inst", id_inst, 32'hA5A5_0000);
    step(1'b1, 1'b0, 32'h0);
    chk("c4_id_pc", id_pc, 32'h4);
    chk("c4_id_inst", id_inst, 32'hA5A5_0004);
    chk("c4_imem_addr", imem_addr, 32'hC);

    // Five-cycle decode stall: buffer fills to two, fetch stops, head stays put.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk1("stall_imem_en", imem_en, 1'b0);
      chk1("stall_id_valid", id_valid, 1'b1);
      chk("stall_id_pc", id_pc, 32'h8);
      chk("stall_id_inst", id_inst, 32'hA5A5_0008);
    end
    step(1'b1, 1'b0, 32'h0);
    chk("release_id_pc", id_pc, 32'h8);
    chk1("release_imem_en", imem_en, 1'b1);
    chk("release_imem_addr", imem_addr, 32'h10);
    step(1'b1, 1'b0, 32'h0);
    chk("order_pc_c", id_pc, 32'hC);
    chk("order_inst_c", id_inst, 32'hA5A5_000C);
    step(1'b1, 1'b0, 32'h0);
    chk("order_pc_10", id_pc, 32'h10);

    // Redirect with one buffered and one in flight.
    step(1'b1, 1'b1, 32'h0000_0100);
    chk1("redir_id_valid", id_valid, 1'b0);
    chk1("redir_imem_en", imem_en, 1'b0);
    step(1'b1, 1'b0, 32'h0);
    chk("redir_next_addr", imem_addr, 32'h100);
    chk1("redir_next_en", imem_en, 1'b1);
    chk1("redir_flushed", id_valid, 1'b0);
    step(1'b1, 1'b0, 32'h0);
    chk1("redir_killed", id_valid, 1'b0);
    chk("redir_addr2", imem_addr, 32'h104);
    step(1'b1, 1'b0, 32'h0);
    chk1("redir_first_valid", id_valid, 1'b1);
    chk("redir_first_pc", id_pc, 32'h100);
    chk("redir_first_inst", id_inst, 32'hA5A5_0100);

    // Address wrap at the top of the space.
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_addr_zero", imem_addr, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_pc_top", id_pc, 32'hFFFF_FFFC);
    chk("wrap_inst_top", id_inst, 32'h5A5A_FFFC);
    step(1'b1, 1'b0, 32'h0);
    chk("wrap_pc_zero", id_pc, 32'h0);
    chk("wrap_inst_zero", id_inst, 32'hA5A5_0000);

    // Misaligned target passes through unmodified.
    step(1'b1, 1'b1, 32'h0000_0102);
    step(1'b1, 1'b0, 32'h0);
    chk("mis_addr", imem_addr, 32'h102);
    step(1'b1, 1'b0, 32'h0);
    chk("mis_addr2", imem_addr, 32'h106);
    step(1'b1, 1'b0, 32'h0);
    chk("mis_id_pc", id_pc, 32'h102);
    chk("mis_id_inst", id_inst, 32'hA5A5_0102);

    // Redirect while stalled with a full buffer.
    step(1'b0, 1'b0, 32'h0);
    chk1("full_imem_en", imem_en, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0200);
    chk1("full_redir_valid", id_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk("full_redir_addr", imem_addr, 32'h200);
    chk1("full_redir_flushed", id_valid, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk("full_redir_addr2", imem_addr, 32'h204);
    step(1'b0, 1'b0, 32'h0);
    chk("full_redir_pc", id_pc, 32'h200);
    chk("full_redir_inst", id_inst, 32'hA5A5_0200);

    // Reset with a buffered entry and the 0x204 read in flight.
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    id_ready = 1'b1;
    #1;
    chk1("rst2_imem_en", imem_en, 1'b0);
    chk("rst2_imem_addr", imem_addr, 32'h0);
    chk1("rst2_id_valid", id_valid, 1'b0);
    chk("rst2_id_inst", id_inst, 32'h0);
    chk("rst2_id_pc", id_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("rst2_c1_addr", imem_addr, 32'h0);
    chk("rst2_c1_inst", id_inst, 32'h0);
    chk1("rst2_c1_valid", id_valid, 1'b0);
    step(1'b1, 1'b0, 32'h0);
    chk1("rst2_c2_valid", id_valid, 1'b0);
    chk("rst2_c2_inst", id_inst, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk1("rst2_c3_valid", id_valid, 1'b1);
    chk("rst2_c3_pc", id_pc, 32'h0);
    chk("rst2_c3_inst", id_inst, 32'hA5A5_0000);

    // Ten accepts (cycles 3..12) then three stall cycles.
    for (int k = 4; k <= 12; k++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("run_id_pc", id_pc, 32'(k - 3) * 32'd4);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("perfstall_id_pc", id_pc, 32'h28);
    end
    step(1'b0, 1'b0, 32'h0);
    chk1("end_id_valid", id_valid, 1'b1);
    chk("end_id_pc", id_pc, 32'h28);
`ifdef FB_FETCH_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'd10);
    chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
